line_mem_responder: RTL and testbench
=====================================

# line_mem_responder

Line-granular main-memory responder serving the cache's swap-in/swap-out port: accepts one level-held read or write request per transaction, models a fixed access latency, then returns a single-cycle `gnt` pulse. Read data is registered and held stable after `gnt`, so the requester can consume it in the following cycle. Sits directly below the cache as its backing store and also exports transaction counters for miss-traffic profiling in the cache lab.

## Interface

- `LINE_ADDR_LEN`, default 3: log2 of words per line; `LINE_SIZE = 2**LINE_ADDR_LEN`.
- `ADDR_LEN`, default 9: line address width; capacity is `2**ADDR_LEN` lines.
- `LATENCY`, default 4: BUSY cycles per access; legal range ≥1.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `gnt`  out  1  one-cycle completion pulse.
- `addr`  in  `ADDR_LEN`  line address; sampled at request acceptance only.
- `rd_req`  in  1  read request, level, held by the requester until `gnt`.
- `rd_line`  out  32 × `LINE_SIZE` (unpacked array)  registered read line.
- `wr_req`  in  1  write request, level, held until `gnt`.
- `wr_line`  in  32 × `LINE_SIZE` (unpacked array)  write line; sampled at acceptance.
- `rd_cnt`  out  32  completed reads since reset.
- `wr_cnt`  out  32  completed writes since reset.

## Operation

- Storage is `2**ADDR_LEN` × `LINE_SIZE` × 32-bit words. At time zero, word i of line a holds `{a, i}`, zero-extended to 32 bits. `rst` never alters storage.
- FSM states:
  - IDLE: `gnt`=0. If `wr_req`, latch `addr` and `wr_line`, set op=WRITE and cnt=`LATENCY`-1, then go to BUSY. Else if `rd_req`, latch `addr`, set op=READ and cnt=`LATENCY`-1, then go to BUSY. `wr_req` has priority when both are high; the read is accepted in a later IDLE cycle if it is still held.
  - BUSY: if cnt==0, perform the access and go to GNT. A READ loads `rd_line` from storage. A WRITE stores the latched line. Otherwise decrement cnt.
  - GNT: `gnt`=1. Increment `rd_cnt` or `wr_cnt` (32-bit, wraps). Unconditionally go to IDLE. Requests are not sampled in GNT.
- Once accepted, a transaction is committed. Dropping the request during BUSY does not abort it; `gnt` still pulses.
- `addr` and `wr_line` changes after acceptance are ignored.
- `rd_line` holds its value until the next READ completes. WRITEs do not modify `rd_line`, even to the same line.
- Read-after-write to the same line returns the written data.
- Reset values: state IDLE, `gnt`=0, `rd_line` all zeros, `rd_cnt`=`wr_cnt`=0, cnt=0. A reset during BUSY discards the transaction: a pending write is never committed and no `gnt` is issued.

## Timing

- Let t0 be the rising edge at which a request is accepted in IDLE.
  - `gnt` rises at edge t0+`LATENCY` and falls at t0+`LATENCY`+1.
  - The storage access and the `rd_line` update also occur at t0+`LATENCY`.
  - The counters update at t0+`LATENCY`+1.
- The earliest next acceptance is edge t0+`LATENCY`+2. The minimum transaction period is `LATENCY`+2 cycles.
- Requester contract:
  - Drop the request at the edge where it samples `gnt`=1.
  - `rd_line` remains valid in the cycle after `gnt` and beyond.
  - Back-to-back write-then-read, as in a dirty swap-out followed by swap-in, is accepted at t0+`LATENCY`+2.
- `rst` is sampled on the clock edge and has priority over every transition.

## Test plan

- Reset then read: `LATENCY`=4, read line 5 accepted at t0. Required: `gnt` high only in [t0+4, t0+5); `rd_line`[i] = (5<<3)|i; `rd_cnt`=1 after t0+5.
- Write then read back: write line 0x1A3 with word i = 0xA5A50000+i, then read line 0x1A3. Required: the read returns the written values; `rd_line` is unchanged after the write's `gnt`; `wr_cnt`=1, `rd_cnt`=1.
- Simultaneous requests: `rd_req`=`wr_req`=1 to line 7, both held until each receives its `gnt`. Required: the write completes first (`wr_cnt`=1), the read is accepted at t0+`LATENCY`+2, and the read returns the new data.
- Request dropped mid-BUSY: read accepted, `rd_req` deasserted at t0+1. Required: `gnt` still pulses at t0+`LATENCY`; `rd_cnt` increments.
- Reset mid-write: write to line 3 accepted, `rst` asserted at t0+2. Required: no `gnt`; counters and `rd_line` are 0; a subsequent read of line 3 returns the init pattern `{3,i}`.
- `LATENCY`=1 dirty-swap sequence driven by a cache model: write line X, then read line Y. Required: `gnt` pulses are 3 cycles apart; no spurious third `gnt` is issued.

Source files
------------

// File: rtl/line_mem_responder_if.sv
// Swap-in/swap-out port between the cache (master) and its backing
// line memory (slave): level-held requests, one-cycle gnt.
interface line_mem_responder_if #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 9
);
    localparam int LINE_SIZE = 2 ** LINE_ADDR_LEN;

    logic                gnt;
    logic [ADDR_LEN-1:0] addr;
    logic                rd_req;
    logic                wr_req;
    logic [31:0]         rd_line [LINE_SIZE];
    logic [31:0]         wr_line [LINE_SIZE];

    modport master (
        output addr, rd_req, wr_req, wr_line,
        input  gnt, rd_line
    );

    modport slave (
        input  addr, rd_req, wr_req, wr_line,
        output gnt, rd_line
    );
endinterface

// File: rtl/line_mem_responder.sv
// Line-granular main memory behind the cache: fixed-latency access,
// single-cycle gnt, registered read line and completion counters.
module line_mem_responder #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 9,
    parameter int LATENCY       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    line_mem_responder_if.slave  bus,
    output logic [31:0]          rd_cnt,
    output logic [31:0]          wr_cnt
);
    localparam int LINE_SIZE = 2 ** LINE_ADDR_LEN;
    localparam int LINES     = 2 ** ADDR_LEN;
    localparam int CW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, GNT} state_t;
    typedef enum logic {OP_READ, OP_WRITE} op_t;

    state_t              state;
    state_t              state_nx;
    op_t                 op;
    logic [CW-1:0]       cnt;
    logic [ADDR_LEN-1:0] addr_q;
    logic [31:0]         line_q [LINE_SIZE];
    logic                accept_wr;
    logic                accept_rd;
    logic                access;

    // Stored as data ^ {line, word}: the 2-state zero power-up value
    // then reads back as the required {line, word} init pattern.
    bit [31:0] mem_x [LINES][LINE_SIZE];

    function automatic logic [31:0] pat(input logic [ADDR_LEN-1:0] a,
                                        input int i);
        return 32'({a, LINE_ADDR_LEN'(i)});
    endfunction

    always_comb begin
        accept_wr = (state == IDLE) && bus.wr_req;
        accept_rd = (state == IDLE) && !bus.wr_req && bus.rd_req;
        access    = (state == BUSY) && (cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept_wr || accept_rd) state_nx = BUSY;
            BUSY: if (cnt == '0) state_nx = GNT;
            GNT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.gnt = (state == GNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op     <= OP_READ;
            cnt    <= '0;
            addr_q <= '0;
            rd_cnt <= '0;
            wr_cnt <= '0;
            for (int i = 0; i < LINE_SIZE; i++) bus.rd_line[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept_wr || accept_rd) begin
                        op     <= accept_wr ? OP_WRITE : OP_READ;
                        cnt    <= CNT_LOAD;
                        addr_q <= bus.addr;
                    end
                end
                BUSY: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else if (op == OP_READ)
                        for (int i = 0; i < LINE_SIZE; i++)
                            bus.rd_line[i] <= mem_x[addr_q][i] ^ pat(addr_q, i);
                end
                GNT: begin
                    if (op == OP_WRITE) wr_cnt <= wr_cnt + 32'd1;
                    else                rd_cnt <= rd_cnt + 32'd1;
                end
                default: ;
            endcase
        end
    end

    // Storage and the write-data latch are deliberately outside reset.
    always_ff @(posedge clk) begin
        if (accept_wr && !rst) line_q <= bus.wr_line;
        if (access && op == OP_WRITE && !rst)
            for (int i = 0; i < LINE_SIZE; i++)
                mem_x[addr_q][i] <= line_q[i] ^ pat(addr_q, i);
    end
endmodule

// File: tb/tb_line_mem_responder.sv
// Directed + randomized bench for line_mem_responder (LATENCY 4 and 1)
// against an associative-array line model.
module tb_line_mem_responder;
    localparam int LA = 3;
    localparam int AL = 9;
    localparam int LS = 1 << LA;
    localparam int L4 = 4;

    typedef logic [31:0] line_t [LS];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_mem_responder_if #(.LINE_ADDR_LEN(LA), .ADDR_LEN(AL)) b4 ();
    line_mem_responder_if #(.LINE_ADDR_LEN(LA), .ADDR_LEN(AL)) b1 ();

    logic [31:0] rc4, wc4, rc1, wc1;

    line_mem_responder #(.LINE_ADDR_LEN(LA), .ADDR_LEN(AL), .LATENCY(L4)) dut4 (
        .clk(clk), .rst(rst), .bus(b4), .rd_cnt(rc4), .wr_cnt(wc4)
    );
    line_mem_responder #(.LINE_ADDR_LEN(LA), .ADDR_LEN(AL), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1), .rd_cnt(rc1), .wr_cnt(wc1)
    );

    int    checks = 0;
    int    errors = 0;
    line_t mdl [int];
    line_t rd_exp;
    int    m_rc, m_wc;

    function automatic line_t mem_line(input int a);
        line_t l;
        if (mdl.exists(a)) return mdl[a];
        for (int i = 0; i < LS; i++) l[i] = (a << LA) | i;
        return l;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt4(output int n);
        n = 0;
        while (b4.gnt !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic post4(input string tag);
        tick();
        chk({tag, ":gnt_fall"}, b4.gnt, 0);
        chk({tag, ":rd_cnt"}, rc4, m_rc);
        chk({tag, ":wr_cnt"}, wc4, m_wc);
        for (int i = 0; i < LS; i++)
            chk($sformatf("%s:rd_line[%0d]", tag, i), b4.rd_line[i], rd_exp[i]);
    endtask

    task automatic txn4(input bit wr, input int a, input line_t ln);
        int    n;
        line_t junk;
        b4.addr    = AL'(a);
        b4.wr_line = ln;
        b4.wr_req  = wr;
        b4.rd_req  = !wr;
        tick();
        for (int i = 0; i < LS; i++) junk[i] = $urandom;
        b4.wr_line = junk;
        b4.addr    = AL'($urandom);
        wait_gnt4(n);
        chk(wr ? "wr_latency" : "rd_latency", n, L4);
        b4.wr_req = 1'b0;
        b4.rd_req = 1'b0;
        if (wr) begin
            mdl[a] = ln;
            m_wc++;
        end else begin
            rd_exp = mem_line(a);
            m_rc++;
        end
        post4(wr ? "wr" : "rd");
    endtask

    initial begin
        line_t ln, zero;
        int    n, a, k, g0, g1, x, y, hits;
        for (int i = 0; i < LS; i++) zero[i] = '0;
        b4.addr = '0; b4.rd_req = 0; b4.wr_req = 0; b4.wr_line = zero;
        b1.addr = '0; b1.rd_req = 0; b1.wr_req = 0; b1.wr_line = zero;
        m_rc = 0; m_wc = 0; rd_exp = zero;

        repeat (3) tick();
        chk("rst:gnt", b4.gnt, 0);
        rst = 1'b0;
        tick();
        chk("rst:gnt_idle", b4.gnt, 0);
        chk("rst:rd_cnt", rc4, 0);
        chk("rst:wr_cnt", wc4, 0);
        chk("rst:rd_line0", b4.rd_line[0], 0);
        chk("rst:rd_line7", b4.rd_line[LS-1], 0);

        // read line 5 after reset
        txn4(1'b0, 5, zero);

        // write 0x1A3, rd_line must still hold line 5, then read back
        for (int i = 0; i < LS; i++) ln[i] = 32'hA5A5_0000 + i;
        txn4(1'b1, 'h1A3, ln);
        txn4(1'b0, 'h1A3, zero);

        // simultaneous requests to line 7: write wins
        for (int i = 0; i < LS; i++) ln[i] = $urandom;
        b4.addr = AL'(7); b4.wr_line = ln;
        b4.wr_req = 1; b4.rd_req = 1;
        wait_gnt4(n);
        chk("sim:wr_latency", n, L4 + 1);
        b4.wr_req = 0;
        mdl[7] = ln; m_wc++;
        post4("sim_wr");
        wait_gnt4(n);
        chk("sim:rd_accept", n, L4 + 1);
        b4.rd_req = 0;
        rd_exp = mem_line(7); m_rc++;
        post4("sim_rd");

        // request dropped one cycle after acceptance
        a = $urandom_range(0, 511);
        b4.addr = AL'(a); b4.rd_req = 1;
        tick();
        b4.rd_req = 0;
        wait_gnt4(n);
        chk("drop:latency", n, L4);
        rd_exp = mem_line(a); m_rc++;
        post4("drop");

        // reset two cycles into a write of line 3
        for (int i = 0; i < LS; i++) ln[i] = $urandom | 32'h8000_0000;
        b4.addr = AL'(3); b4.wr_line = ln; b4.wr_req = 1;
        tick();
        b4.wr_req = 0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hits = 0;
        for (int c = 0; c < 8; c++) begin
            if (b4.gnt === 1'b1) hits++;
            tick();
        end
        chk("rstw:no_gnt", hits, 0);
        m_rc = 0; m_wc = 0; rd_exp = zero;
        chk("rstw:rd_cnt", rc4, 0);
        chk("rstw:wr_cnt", wc4, 0);
        for (int i = 0; i < LS; i++)
            chk($sformatf("rstw:rd_line[%0d]", i), b4.rd_line[i], 0);
        txn4(1'b0, 3, zero);

        // randomized traffic, concentrated on a few lines for RAW hits
        for (int t = 0; t < 40; t++) begin
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 511)
                                             : 16 + $urandom_range(0, 7);
            for (int i = 0; i < LS; i++) ln[i] = $urandom;
            txn4(1'($urandom_range(0, 1)), a, ln);
        end

        // LATENCY=1 dirty swap: write X then immediately read Y
        x = $urandom_range(0, 511);
        y = (x + 1 + $urandom_range(0, 509)) % 512;
        for (int i = 0; i < LS; i++) ln[i] = $urandom;
        b1.addr = AL'(x); b1.wr_line = ln; b1.wr_req = 1;
        k = 0; g0 = 0; g1 = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (b1.gnt === 1'b1) begin
                if (k == 0) begin
                    g0 = c;
                    b1.wr_req = 0;
                    b1.addr = AL'(y);
                    b1.rd_req = 1;
                end else if (k == 1) begin
                    g1 = c;
                    b1.rd_req = 0;
                end
                k++;
            end
        end
        chk("swap:pulses", k, 2);
        chk("swap:first_gnt", g0, 2);
        chk("swap:spacing", g1 - g0, 3);
        chk("swap:wr_cnt", wc1, 1);
        chk("swap:rd_cnt", rc1, 1);
        for (int i = 0; i < LS; i++)
            chk($sformatf("swap:rd_line[%0d]", i), b1.rd_line[i], (y << LA) | i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
